// File: rtl/dcache_fill_unit.sv
// Cache miss handler: optional dirty-victim writeback, then a word-by-word block fill returned to the cache.
// Define DCACHE_FILL_WRITEBACK_EN to compile in the victim writeback path (write-back cache).
module dcache_fill_unit #(
  parameter int unsigned ADDR_BITS        = 8,
  parameter int unsigned DATA_BITS        = 8,
  parameter int unsigned CACHE_BLOCK_SIZE = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  miss_valid,
  output logic                                  miss_ready,
  input  logic [ADDR_BITS-1:0]                  miss_address,
  input  logic                                  victim_dirty,
  input  logic [ADDR_BITS-1:0]                  victim_address,
  input  logic [CACHE_BLOCK_SIZE*DATA_BITS-1:0] victim_data,
  output logic                                  fill_valid,
  input  logic                                  fill_ready,
  output logic [ADDR_BITS-1:0]                  fill_address,
  output logic [CACHE_BLOCK_SIZE*DATA_BITS-1:0] fill_data,
  output logic                                  mem_read_valid,
  output logic [ADDR_BITS-1:0]                  mem_read_address,
  input  logic                                  mem_read_ready,
  input  logic [DATA_BITS-1:0]                  mem_read_data,
  output logic                                  mem_write_valid,
  output logic [ADDR_BITS-1:0]                  mem_write_address,
  output logic [DATA_BITS-1:0]                  mem_write_data,
  input  logic                                  mem_write_ready
);

  localparam int unsigned OFF_BITS = $clog2(CACHE_BLOCK_SIZE);
  localparam int unsigned CNT_BITS = (OFF_BITS == 0) ? 1 : OFF_BITS;
  localparam logic [ADDR_BITS-1:0] OFF_MASK  = ADDR_BITS'(CACHE_BLOCK_SIZE - 1);
  localparam logic [CNT_BITS-1:0]  LAST_WORD = CNT_BITS'(CACHE_BLOCK_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    WB_RELEASE,
    FILL_REQ,
    FILL_RELEASE,
    RESPOND
  } state_t;

  state_t                state, next_state;
  logic [CNT_BITS-1:0]   cnt, cnt_next;
  logic                  accept, capture;
  logic [ADDR_BITS-1:0]  word_offset;
  logic [DATA_BITS-1:0]  fill_words [CACHE_BLOCK_SIZE];

  // Offset is masked into the block so the top block never wraps to address 0.
  assign word_offset = ADDR_BITS'(cnt) & OFF_MASK;

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (miss_valid && miss_ready) begin
          accept   = 1'b1;
          cnt_next = '0;
`ifdef DCACHE_FILL_WRITEBACK_EN
          next_state = victim_dirty ? WB_REQ : FILL_REQ;
`else
          next_state = FILL_REQ;
`endif
        end
      end
`ifdef DCACHE_FILL_WRITEBACK_EN
      WB_REQ: begin
        if (mem_write_valid && mem_write_ready) next_state = WB_RELEASE;
      end
      WB_RELEASE: begin
        if (!mem_write_ready) begin
          if (cnt == LAST_WORD) begin
            cnt_next   = '0;
            next_state = FILL_REQ;
          end else begin
            cnt_next   = cnt + 1'b1;
            next_state = WB_REQ;
          end
        end
      end
`endif
      FILL_REQ: begin
        if (mem_read_valid && mem_read_ready) begin
          capture    = 1'b1;
          next_state = FILL_RELEASE;
        end
      end
      FILL_RELEASE: begin
        if (!mem_read_ready) begin
          if (cnt == LAST_WORD) begin
            cnt_next   = '0;
            next_state = RESPOND;
          end else begin
            cnt_next   = cnt + 1'b1;
            next_state = FILL_REQ;
          end
        end
      end
      RESPOND: begin
        if (fill_valid && fill_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Valids lag the state by a cycle, so the address register (fed from the newly captured base) is settled when valid rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      miss_ready       <= 1'b0;
      fill_valid       <= 1'b0;
      fill_address     <= '0;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      for (int unsigned i = 0; i < CACHE_BLOCK_SIZE; i++) fill_words[i] <= '0;
    end else begin
      state            <= next_state;
      cnt              <= cnt_next;
      miss_ready       <= (next_state == IDLE);
      fill_valid       <= (state == RESPOND) && !(fill_valid && fill_ready);
      mem_read_valid   <= (state == FILL_REQ) && !(mem_read_valid && mem_read_ready);
      mem_read_address <= fill_address | word_offset;
      if (accept) fill_address <= miss_address & ~OFF_MASK;
      if (capture) fill_words[cnt] <= mem_read_data;
    end
  end

  for (genvar g = 0; g < CACHE_BLOCK_SIZE; g++) begin : g_pack
    assign fill_data[g*DATA_BITS +: DATA_BITS] = fill_words[g];
  end

`ifdef DCACHE_FILL_WRITEBACK_EN
  logic [ADDR_BITS-1:0] victim_base;
  logic [DATA_BITS-1:0] victim_words [CACHE_BLOCK_SIZE];

  always_ff @(posedge clk) begin
    if (accept) begin
      victim_base <= victim_address & ~OFF_MASK;
      for (int unsigned i = 0; i < CACHE_BLOCK_SIZE; i++)
        victim_words[i] <= victim_data[i*DATA_BITS +: DATA_BITS];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_write_valid   <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
    end else begin
      mem_write_valid   <= (state == WB_REQ) && !(mem_write_valid && mem_write_ready);
      mem_write_address <= victim_base | word_offset;
      mem_write_data    <= victim_words[cnt];
    end
  end
`else
  logic unused_wb;
  assign unused_wb         = ^{victim_dirty, victim_address, victim_data, mem_write_ready};
  assign mem_write_valid   = 1'b0;
  assign mem_write_address = '0;
  assign mem_write_data    = '0;
`endif

endmodule

// File: tb/tb_dcache_fill_unit.sv
// Directed bench for dcache_fill_unit: memory controller model asserts ready one cycle after valid, for one cycle.
module tb_dcache_fill_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        miss_valid, miss_ready;
  logic [7:0]  miss_address;
  logic        victim_dirty;
  logic [7:0]  victim_address;
  logic [31:0] victim_data;
  logic        fill_valid, fill_ready;
  logic [7:0]  fill_address;
  logic [31:0] fill_data;
  logic        mem_read_valid, mem_read_ready;
  logic [7:0]  mem_read_address, mem_read_data;
  logic        mem_write_valid, mem_write_ready;
  logic [7:0]  mem_write_address, mem_write_data;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dcache_fill_unit #(.ADDR_BITS(8), .DATA_BITS(8), .CACHE_BLOCK_SIZE(4)) dut (
    .clk(clk), .reset(reset),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_address(miss_address),
    .victim_dirty(victim_dirty), .victim_address(victim_address), .victim_data(victim_data),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_address(fill_address), .fill_data(fill_data),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready)
  );

  // Memory: word at address a holds a ^ 0x80; ready pulses one cycle after valid is seen.
  logic rd_rdy, wr_rdy;
  always @(posedge clk) begin
    if (reset) begin
      rd_rdy <= 1'b0;
      wr_rdy <= 1'b0;
    end else begin
      rd_rdy <= mem_read_valid && !rd_rdy;
      wr_rdy <= mem_write_valid && !wr_rdy;
    end
  end
  assign mem_read_ready  = rd_rdy;
  assign mem_write_ready = wr_rdy;
  assign mem_read_data   = mem_read_address ^ 8'h80;

  logic [7:0]  rd_log [$];
  logic [15:0] wr_log [$];
  int          both_valid;
  bit          wr_seen, rd_seen;
  int          wr_at_first_rd;

  always @(negedge clk) begin
    if (mem_read_valid === 1'b1 && mem_write_valid === 1'b1) both_valid++;
    if (mem_write_valid === 1'b1) wr_seen = 1'b1;
    if (mem_read_valid === 1'b1 && !rd_seen) begin
      rd_seen = 1'b1;
      wr_at_first_rd = wr_log.size();
    end
    if (mem_read_valid === 1'b1 && mem_read_ready === 1'b1) rd_log.push_back(mem_read_address);
    if (mem_write_valid === 1'b1 && mem_write_ready === 1'b1)
      wr_log.push_back({mem_write_address, mem_write_data});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_log.delete();
    wr_log.delete();
    both_valid = 0;
    wr_seen = 1'b0;
    rd_seen = 1'b0;
    wr_at_first_rd = -1;
  endtask

  task automatic issue_miss(input logic [7:0] a, input logic d, input logic [7:0] va, input logic [31:0] vd);
    miss_valid = 1'b1; miss_address = a; victim_dirty = d; victim_address = va; victim_data = vd;
    tick();
    miss_valid = 1'b0; victim_dirty = 1'b0;
  endtask

  // Returns the cycle (acceptance = 0) on which fill_valid is first seen; 200 on timeout.
  task automatic wait_fill(output int cyc);
    cyc = 1;
    while (fill_valid !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    vectors++; if (miss_ready !== 1'b0) begin miscompares++; $display("FAIL reset_miss_ready got=%0b exp=0", miss_ready); end
    vectors++; if (fill_valid !== 1'b0) begin miscompares++; $display("FAIL reset_fill_valid got=%0b exp=0", fill_valid); end
    vectors++; if (mem_read_valid !== 1'b0) begin miscompares++; $display("FAIL reset_read_valid got=%0b exp=0", mem_read_valid); end
    vectors++; if (mem_write_valid !== 1'b0) begin miscompares++; $display("FAIL reset_write_valid got=%0b exp=0", mem_write_valid); end
    vectors++; if (fill_data !== 32'h0) begin miscompares++; $display("FAIL reset_fill_data got=%08h exp=0", fill_data); end
    reset = 1'b0;
    tick();
    vectors++; if (miss_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_miss_ready got=%0b exp=1", miss_ready); end
  endtask

  task automatic test_clean_miss();
    int cyc;
    logic [7:0] got;
    clear_logs();
    fill_ready = 1'b1;
    issue_miss(8'h23, 1'b0, 8'h00, 32'h0);
    vectors++; if (miss_ready !== 1'b0) begin miscompares++; $display("FAIL clean_busy_miss_ready got=%0b exp=0", miss_ready); end
    wait_fill(cyc);
    vectors++; if (cyc != 18) begin miscompares++; $display("FAIL clean_latency got=%0d exp=18", cyc); end
    vectors++; if (fill_address !== 8'h20) begin miscompares++; $display("FAIL clean_fill_address got=%02h exp=20", fill_address); end
    vectors++; if (fill_data !== 32'hA3A2A1A0) begin miscompares++; $display("FAIL clean_fill_data got=%08h exp=A3A2A1A0", fill_data); end
    vectors++; if (rd_log.size() != 4) begin miscompares++; $display("FAIL clean_read_count got=%0d exp=4", rd_log.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < rd_log.size()) ? rd_log[i] : 8'hxx;
      vectors++; if (got !== 8'(32'h20 + i)) begin miscompares++; $display("FAIL clean_read_addr[%0d] got=%02h exp=%02h", i, got, 8'(32'h20 + i)); end
    end
    vectors++; if (wr_log.size() != 0) begin miscompares++; $display("FAIL clean_write_count got=%0d exp=0", wr_log.size()); end
    tick();
    vectors++; if (fill_valid !== 1'b0) begin miscompares++; $display("FAIL clean_fill_drop got=%0b exp=0", fill_valid); end
    vectors++; if (miss_ready !== 1'b1) begin miscompares++; $display("FAIL clean_ready_return got=%0b exp=1", miss_ready); end
    fill_ready = 1'b0;
  endtask

  task automatic test_dirty_miss();
    int cyc;
    logic [7:0]  got;
    logic [15:0] wgot;
    clear_logs();
    fill_ready = 1'b1;
    issue_miss(8'h80, 1'b1, 8'h40, 32'h44332211);
    wait_fill(cyc);
`ifdef DCACHE_FILL_WRITEBACK_EN
    vectors++; if (cyc != 34) begin miscompares++; $display("FAIL dirty_latency got=%0d exp=34", cyc); end
    vectors++; if (wr_log.size() != 4) begin miscompares++; $display("FAIL dirty_write_count got=%0d exp=4", wr_log.size()); end
    for (int i = 0; i < 4; i++) begin
      wgot = (i < wr_log.size()) ? wr_log[i] : 16'hxxxx;
      vectors++; if (wgot !== {8'(32'h40 + i), 8'(17 * (i + 1))}) begin
        miscompares++; $display("FAIL dirty_write[%0d] got=%04h exp=%02h%02h", i, wgot, 8'(32'h40 + i), 8'(17 * (i + 1)));
      end
    end
    vectors++; if (wr_at_first_rd != 4) begin miscompares++; $display("FAIL dirty_wb_before_fill got=%0d exp=4", wr_at_first_rd); end
`else
    vectors++; if (cyc != 18) begin miscompares++; $display("FAIL dirty_latency got=%0d exp=18", cyc); end
    vectors++; if (wr_seen !== 1'b0) begin miscompares++; $display("FAIL dirty_write_valid_seen got=%0b exp=0", wr_seen); end
`endif
    vectors++; if (both_valid != 0) begin miscompares++; $display("FAIL dirty_overlap got=%0d exp=0", both_valid); end
    vectors++; if (rd_log.size() != 4) begin miscompares++; $display("FAIL dirty_read_count got=%0d exp=4", rd_log.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < rd_log.size()) ? rd_log[i] : 8'hxx;
      vectors++; if (got !== 8'(32'h80 + i)) begin miscompares++; $display("FAIL dirty_read_addr[%0d] got=%02h exp=%02h", i, got, 8'(32'h80 + i)); end
    end
    vectors++; if (fill_address !== 8'h80) begin miscompares++; $display("FAIL dirty_fill_address got=%02h exp=80", fill_address); end
    vectors++; if (fill_data !== 32'h03020100) begin miscompares++; $display("FAIL dirty_fill_data got=%08h exp=03020100", fill_data); end
    tick();
    fill_ready = 1'b0;
  endtask

  task automatic test_top_of_space();
    int cyc;
    logic [7:0] got;
    clear_logs();
    fill_ready = 1'b1;
    issue_miss(8'hFE, 1'b0, 8'h00, 32'h0);
    wait_fill(cyc);
    vectors++; if (rd_log.size() != 4) begin miscompares++; $display("FAIL top_read_count got=%0d exp=4", rd_log.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < rd_log.size()) ? rd_log[i] : 8'hxx;
      vectors++; if (got !== 8'(32'hFC + i)) begin miscompares++; $display("FAIL top_read_addr[%0d] got=%02h exp=%02h", i, got, 8'(32'hFC + i)); end
    end
    vectors++; if (fill_address !== 8'hFC) begin miscompares++; $display("FAIL top_fill_address got=%02h exp=FC", fill_address); end
    vectors++; if (fill_data !== 32'h7F7E7D7C) begin miscompares++; $display("FAIL top_fill_data got=%08h exp=7F7E7D7C", fill_data); end
    tick();
    fill_ready = 1'b0;
  endtask

  task automatic test_fill_backpressure();
    int cyc;
    clear_logs();
    fill_ready = 1'b0;
    issue_miss(8'h23, 1'b0, 8'h00, 32'h0);
    wait_fill(cyc);
    vectors++; if (cyc != 18) begin miscompares++; $display("FAIL bp_latency got=%0d exp=18", cyc); end
    miss_valid = 1'b1;
    miss_address = 8'h55;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++; if (fill_valid !== 1'b1) begin miscompares++; $display("FAIL bp_fill_valid[%0d] got=%0b exp=1", i, fill_valid); end
      vectors++; if (fill_data !== 32'hA3A2A1A0) begin miscompares++; $display("FAIL bp_fill_data[%0d] got=%08h exp=A3A2A1A0", i, fill_data); end
      vectors++; if (miss_ready !== 1'b0) begin miscompares++; $display("FAIL bp_miss_ready[%0d] got=%0b exp=0", i, miss_ready); end
    end
    fill_ready = 1'b1;
    miss_valid = 1'b0;
    tick();
    fill_ready = 1'b0;
    vectors++; if (fill_valid !== 1'b0) begin miscompares++; $display("FAIL bp_fill_drop got=%0b exp=0", fill_valid); end
    vectors++; if (miss_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_return got=%0b exp=1", miss_ready); end
    tick(); tick(); tick();
    vectors++; if (mem_read_valid !== 1'b0) begin miscompares++; $display("FAIL bp_no_queued_read got=%0b exp=0", mem_read_valid); end
    vectors++; if (rd_log.size() != 4) begin miscompares++; $display("FAIL bp_read_count got=%0d exp=4", rd_log.size()); end
  endtask

  task automatic test_reset_mid_fill();
    int cyc;
    int n;
    logic [7:0] got;
    clear_logs();
    fill_ready = 1'b1;
    issue_miss(8'h23, 1'b0, 8'h00, 32'h0);
    n = 0;
    while (rd_log.size() < 2 && n < 50) begin
      tick();
      n++;
    end
    vectors++; if (rd_log.size() != 2) begin miscompares++; $display("FAIL mid_two_words got=%0d exp=2", rd_log.size()); end
    reset = 1'b1;
    tick();
    vectors++; if (miss_ready !== 1'b0) begin miscompares++; $display("FAIL mid_miss_ready got=%0b exp=0", miss_ready); end
    vectors++; if (fill_valid !== 1'b0) begin miscompares++; $display("FAIL mid_fill_valid got=%0b exp=0", fill_valid); end
    vectors++; if (mem_read_valid !== 1'b0) begin miscompares++; $display("FAIL mid_read_valid got=%0b exp=0", mem_read_valid); end
    vectors++; if (mem_write_valid !== 1'b0) begin miscompares++; $display("FAIL mid_write_valid got=%0b exp=0", mem_write_valid); end
    vectors++; if (mem_read_address !== 8'h00) begin miscompares++; $display("FAIL mid_read_address got=%02h exp=00", mem_read_address); end
    vectors++; if (fill_address !== 8'h00) begin miscompares++; $display("FAIL mid_fill_address got=%02h exp=00", fill_address); end
    vectors++; if (fill_data !== 32'h0) begin miscompares++; $display("FAIL mid_fill_data got=%08h exp=0", fill_data); end
    reset = 1'b0;
    tick();
    clear_logs();
    vectors++; if (miss_ready !== 1'b1) begin miscompares++; $display("FAIL mid_ready_after got=%0b exp=1", miss_ready); end
    issue_miss(8'h10, 1'b0, 8'h00, 32'h0);
    wait_fill(cyc);
    vectors++; if (cyc != 18) begin miscompares++; $display("FAIL mid_latency got=%0d exp=18", cyc); end
    vectors++; if (fill_address !== 8'h10) begin miscompares++; $display("FAIL mid_fill_address2 got=%02h exp=10", fill_address); end
    vectors++; if (fill_data !== 32'h93929190) begin miscompares++; $display("FAIL mid_fill_data2 got=%08h exp=93929190", fill_data); end
    for (int i = 0; i < 4; i++) begin
      got = (i < rd_log.size()) ? rd_log[i] : 8'hxx;
      vectors++; if (got !== 8'(32'h10 + i)) begin miscompares++; $display("FAIL mid_read_addr[%0d] got=%02h exp=%02h", i, got, 8'(32'h10 + i)); end
    end
    tick();
    fill_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    miss_valid = 1'b0; miss_address = '0;
    victim_dirty = 1'b0; victim_address = '0; victim_data = '0;
    fill_ready = 1'b0;
    clear_logs();
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_top_of_space();
    test_fill_backpressure();
    test_reset_mid_fill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/dcache_fill_unit.md
# dcache_fill_unit

Miss-handling stage directly downstream of `dcache`: accepts one block-miss request at a time, writes back a dirty victim block word-by-word, then fetches the missing block word-by-word through one memory-controller channel. Returns the assembled block to the cache for installation. Sits between the cache's miss port and one channel of the data memory controller; one instance per cache bank.

## Interface
Parameters:
- `ADDR_BITS`, 8, byte address width
- `DATA_BITS`, 8, memory word width
- `CACHE_BLOCK_SIZE`, 4, words per block; power of two, ≥1

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `miss_valid`  in  1  cache presents a miss
- `miss_ready`  out  1  unit idle and accepting
- `miss_address`  in  ADDR_BITS  missing address; offset bits ignored
- `victim_dirty`  in  1  victim block must be written back
- `victim_address`  in  ADDR_BITS  victim block address; offset bits ignored
- `victim_data`  in  CACHE_BLOCK_SIZE*DATA_BITS  victim block, word i at `[i*DATA_BITS +: DATA_BITS]`
- `fill_valid`  out  1  filled block available
- `fill_ready`  in  1  cache accepts fill
- `fill_address`  out  ADDR_BITS  block-aligned address of the fill
- `fill_data`  out  CACHE_BLOCK_SIZE*DATA_BITS  filled block, same packing
- `mem_read_valid`  out  1  / `mem_read_address`  out  ADDR_BITS  / `mem_read_ready`  in  1  / `mem_read_data`  in  DATA_BITS
- `mem_write_valid`  out  1  / `mem_write_address`  out  ADDR_BITS  / `mem_write_data`  out  DATA_BITS  / `mem_write_ready`  in  1

## Operation
- States: IDLE, WB_REQ, WB_RELEASE, FILL_REQ, FILL_RELEASE, RESPOND.
- IDLE: `miss_ready`=1. On `miss_valid && miss_ready`, register block-aligned miss/victim addresses, `victim_data`, `victim_dirty`; word counter=0. Go WB_REQ if dirty (and writeback compiled in), else FILL_REQ.
- WB_REQ: `mem_write_valid`=1, address = victim base + counter, data = victim word[counter]. On `mem_write_ready` sampled high: drop valid, go WB_RELEASE.
- WB_RELEASE: wait for `mem_write_ready`=0. Then if counter = CACHE_BLOCK_SIZE-1, counter=0 and go FILL_REQ; else increment, go WB_REQ.
- FILL_REQ / FILL_RELEASE: same protocol on read channel; on ready, capture `mem_read_data` into word[counter] of the fill buffer.
- After last fill word released: RESPOND, `fill_valid`=1 with `fill_address` = miss base. On `fill_ready`: drop `fill_valid`, go IDLE.
- Writeback always completes before the first fill read (same-block ordering guarantee).
- Addresses: base + offset computed within the block only; counter width `$clog2(CACHE_BLOCK_SIZE)`, min 1. Block at top of address space (e.g. base 0xFC, size 4) issues 0xFC..0xFF, never wraps. CACHE_BLOCK_SIZE=1: single word, no offset bits.
- Memory protocol matches the controller: valid held until ready; valid dropped after ready; next request only after ready returns low. Never assert read and write valid together.

## Timing
- Reset: all outputs 0 (`miss_ready`=0 during reset, 1 first cycle after), state IDLE, fill buffer and counter cleared.
- Reset mid-operation: abandon transfer immediately; valid outputs low next cycle; partial data discarded; no fill returned.
- `miss_ready` low from the cycle after acceptance until the cycle after fill handshake.
- All outputs registered. Request valid rises the cycle after entering *_REQ; drops the cycle after ready sampled high.
- With a controller taking 1 cycle to assert ready and 1 cycle to release: 4 cycles/word; clean miss of 4 words accepted at cycle 0 gives `fill_valid` at cycle 18, dirty miss at cycle 34.
- `fill_ready` already high when RESPOND entered: handshake completes in one cycle of `fill_valid`.
- `miss_valid` held during busy: ignored, not queued.

## Configuration
- `DCACHE_FILL_WRITEBACK_EN` defined: behaviour above; dirty victims written back.
- Undefined: `victim_dirty`, `victim_address`, `victim_data` ignored; WB states never entered; `mem_write_valid`, `mem_write_address`, `mem_write_data` tied 0 (write-through cache).

## Test plan
- Clean miss, address 0x23, size 4 -> reads 0x20,0x21,0x22,0x23 in order; memory returns 0xA0..0xA3 -> `fill_address`=0x20, `fill_data`=0xA3A2A1A0.
- Dirty miss, victim 0x40 data 0x44332211, miss 0x80 (WRITEBACK_EN) -> writes 0x40=0x11..0x43=0x44, then reads 0x80..0x83; no read before last write released.
- Same dirty miss without macro -> no write valid ever; only reads 0x80..0x83.
- Miss 0xFE -> reads 0xFC..0xFF, no access to 0x00.
- `fill_ready` held low 5 cycles -> `fill_valid` and `fill_data` stable, `miss_ready` stays 0; new `miss_valid` ignored until handshake.
- Reset asserted after second fill word -> next cycle all outputs 0; after release, new miss 0x10 fetches 0x10..0x13 correctly.
